// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  // Beat sequencing for assembling one 32-bit instruction from memory beats.
  typedef enum logic [0:0] {
    S_BEAT0 = 1'b0,
    S_BEAT1 = 1'b1
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Force a byte address onto a 4-byte instruction boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ir_assembler.sv
// Builds the 32-bit instruction word from one or two memory beats.
// With a 16-bit memory the first beat is staged in hi_half and becomes
// the upper half (big-endian); with a 32-bit memory data passes through.
module ir_assembler
  import fetch_pkg::*;
#(
  parameter int MEM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 capture,
  input  logic [MEM_WIDTH-1:0] rdata,
  output logic [31:0]          instr
);

  localparam bit TWO_BEAT = (MEM_WIDTH == 32'sd16);

  logic [31:0] rdata_ext_s;
  logic [15:0] hi_half_r;

  assign rdata_ext_s = 32'(rdata);

  // Stage the first (upper) beat; a redirect or reset discards it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_half_r <= 16'h0000;
    end else if (clear) begin
      hi_half_r <= 16'h0000;
    end else if (capture) begin
      hi_half_r <= rdata_ext_s[15:0];
    end else begin
      hi_half_r <= hi_half_r;
    end
  end

  assign instr = TWO_BEAT ? {hi_half_r, rdata_ext_s[15:0]} : rdata_ext_s;

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: walks the pc through instruction memory,
// assembles 32-bit instructions from 1 or 2 beats and hands them to decode
// through a registered valid/ready output slot. Redirects take priority.
module instruction_fetch_controller
  import fetch_pkg::*;
#(
  parameter int          MEM_WIDTH = 32,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [31:0]          imem_addr,
  input  logic [MEM_WIDTH-1:0] imem_rdata,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_ir,
  output logic                 addr_error
);

  localparam bit TWO_BEAT = (MEM_WIDTH == 32'sd16);

  fetch_state_t state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic         if_valid_r, if_valid_s;
  logic [31:0]  if_pc_r, if_pc_s;
  logic [31:0]  if_ir_r, if_ir_s;
  logic         addr_error_r, addr_error_s;
  logic         capture_s;
  logic         slot_free_s;
  logic [31:0]  instr_s;

  ir_assembler #(.MEM_WIDTH(MEM_WIDTH)) u_ir_assembler (
    .clk     (clk),
    .reset   (reset),
    .clear   (redirect_valid),
    .capture (capture_s),
    .rdata   (imem_rdata),
    .instr   (instr_s)
  );

  assign slot_free_s = !if_valid_r || if_ready;
  assign imem_addr   = (state_r == S_BEAT1) ? (pc_r + 32'd2) : pc_r;

  // Next-state and slot update: redirect first, then beat sequencing.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    if_valid_s   = if_valid_r;
    if_pc_s      = if_pc_r;
    if_ir_s      = if_ir_r;
    addr_error_s = 1'b0;
    capture_s    = 1'b0;
    if (redirect_valid) begin
      pc_s         = align_word(redirect_pc);
      state_s      = S_BEAT0;
      if_valid_s   = 1'b0;
      addr_error_s = |redirect_pc[1:0];
    end else begin
      case (state_r)
        S_BEAT0: begin
          if (TWO_BEAT) begin
            capture_s = 1'b1;
            state_s   = S_BEAT1;
            if (slot_free_s) begin
              if_valid_s = 1'b0;
            end else begin
              if_valid_s = if_valid_r;
            end
          end else if (slot_free_s) begin
            if_valid_s = 1'b1;
            if_pc_s    = pc_r;
            if_ir_s    = instr_s;
            pc_s       = pc_r + 32'd4;
          end else begin
            if_valid_s = if_valid_r;
          end
        end
        S_BEAT1: begin
          if (slot_free_s) begin
            if_valid_s = 1'b1;
            if_pc_s    = pc_r;
            if_ir_s    = instr_s;
            pc_s       = pc_r + 32'd4;
            state_s    = S_BEAT0;
          end else begin
            state_s = S_BEAT1;
          end
        end
        default: begin
          state_s = S_BEAT0;
        end
      endcase
    end
  end

  // State, pc and output slot registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_BEAT0;
      pc_r         <= RESET_PC;
      if_valid_r   <= 1'b0;
      if_pc_r      <= 32'h0000_0000;
      if_ir_r      <= 32'h0000_0000;
      addr_error_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      if_valid_r   <= if_valid_s;
      if_pc_r      <= if_pc_s;
      if_ir_r      <= if_ir_s;
      addr_error_r <= addr_error_s;
    end
  end

  assign if_valid   = if_valid_r;
  assign if_pc      = if_pc_r;
  assign if_ir      = if_ir_r;
  assign addr_error = addr_error_r;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: a 32-bit and a 16-bit memory
// instance share stimulus. Directed tables/sequences cover the corner cases;
// a transaction-level scoreboard checks every cycle, including random traffic.
module tb_instruction_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;

  logic [31:0] a32, a16, pc32, pc16, ir32, ir16;
  logic [31:0] rd32;
  logic [15:0] rd16;
  logic        v32, v16, ae32, ae16;

  logic [31:0] mem32 [64];
  logic [15:0] mem16 [128];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign rd32 = mem32[a32[7:2]];
  assign rd16 = mem16[a16[7:1]];

  instruction_fetch_controller #(.MEM_WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .imem_addr(a32), .imem_rdata(rd32),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(v32), .if_ready(if_ready), .if_pc(pc32), .if_ir(ir32),
    .addr_error(ae32)
  );

  instruction_fetch_controller #(.MEM_WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .imem_addr(a16), .imem_rdata(rd16),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(v16), .if_ready(if_ready), .if_pc(pc16), .if_ir(ir16),
    .addr_error(ae16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Instruction the memory holds at byte address a (d=0: 32-bit, d=1: 16-bit).
  function automatic logic [31:0] word_at(input int d, input logic [31:0] a);
    logic [6:0] h;
    h = a[7:1];
    if (d == 0) return mem32[a[7:2]];
    else        return {mem16[h], mem16[h + 7'd1]};
  endfunction

  // Scoreboard state: the address the next delivered instruction must have.
  logic        p_reset = 1'b1;
  logic        p_redir = 1'b0;
  logic        p_mis   = 1'b0;
  logic        p_rdy   = 1'b0;
  logic        p_v   [2] = '{1'b0, 1'b0};
  logic [31:0] exp_pc[2] = '{32'h0, 32'h0};
  int          hs    [2] = '{0, 0};

  task automatic sb_step(input int d, input logic v, input logic [31:0] pc,
                         input logic [31:0] ir, input logic ae);
    if (p_reset || p_redir)
      chk($sformatf("sb%0d_flush", d), 32'(v), 32'd0);
    else if (p_v[d] && !p_rdy)
      chk($sformatf("sb%0d_hold", d), 32'(v), 32'd1);
    else if (d == 0)
      chk("sb0_rate", 32'(v), 32'd1);
    chk($sformatf("sb%0d_aerr", d), 32'(ae), 32'(!p_reset && p_redir && p_mis));
    if (v) begin
      chk($sformatf("sb%0d_pc", d), pc, exp_pc[d]);
      chk($sformatf("sb%0d_ir", d), ir, word_at(d, exp_pc[d]));
    end
    if (reset) begin
      exp_pc[d] = 32'h0;
    end else begin
      if (v && if_ready) begin
        exp_pc[d] = exp_pc[d] + 32'd4;
        hs[d]++;
      end
      if (redirect_valid) exp_pc[d] = {redirect_pc[31:2], 2'b00};
    end
    p_v[d] = v;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      sb_step(0, v32, pc32, ir32, ae32);
      sb_step(1, v16, pc16, ir16, ae16);
      p_reset = reset;
      p_redir = redirect_valid;
      p_mis   = |redirect_pc[1:0];
      p_rdy   = if_ready;
    end
  end

  task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    reset = rst; redirect_valid = rv; redirect_pc = rpc; if_ready = rdy;
    @(negedge clk);
  endtask

  typedef struct {
    logic        rdy;
    logic        v32;  logic [31:0] pc32; logic [31:0] ir32; logic [31:0] addr32;
    logic        v16;  logic [31:0] pc16; logic [31:0] ir16; logic [31:0] addr16;
  } vec_t;

  vec_t tbl [5];

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    for (int i = 0; i < 64; i++)  mem32[i] = $urandom;
    for (int i = 0; i < 128; i++) mem16[i] = 16'($urandom);
    mem32[0] = 32'h1111_1111; mem32[1] = 32'h2222_2222;
    mem32[2] = 32'h3333_3333; mem32[3] = 32'h4444_4444;
    mem16[0] = 16'hABCD; mem16[1] = 16'h1234; mem16[2] = 16'h5678; mem16[3] = 16'h9ABC;

    // Row i: if_ready driven this cycle, outputs expected in this cycle.
    tbl[0] = '{1'b1, 1'b0, 32'h0, 32'h0,         32'h00, 1'b0, 32'h0, 32'h0,         32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h0, 32'h1111_1111, 32'h04, 1'b0, 32'h0, 32'h0,         32'h2};
    tbl[2] = '{1'b1, 1'b1, 32'h4, 32'h2222_2222, 32'h08, 1'b1, 32'h0, 32'hABCD_1234, 32'h4};
    tbl[3] = '{1'b1, 1'b1, 32'h8, 32'h3333_3333, 32'h0C, 1'b0, 32'h0, 32'h0,         32'h6};
    tbl[4] = '{1'b1, 1'b1, 32'hC, 32'h4444_4444, 32'h10, 1'b1, 32'h4, 32'h5678_9ABC, 32'h8};

    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst_v32", 32'(v32), 32'd0);   chk("rst_v16", 32'(v16), 32'd0);
    chk("rst_pc32", pc32, 32'h0);      chk("rst_ir32", ir32, 32'h0);
    chk("rst_ir16", ir16, 32'h0);      chk("rst_ae32", 32'(ae32), 32'd0);
    chk("rst_a32", a32, 32'h0);        chk("rst_a16", a16, 32'h0);

    // Streaming after reset, if_ready held high.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'h0, tbl[i].rdy);
      chk("tbl_v32", 32'(v32), 32'(tbl[i].v32));
      chk("tbl_a32", a32, tbl[i].addr32);
      if (tbl[i].v32) begin
        chk("tbl_pc32", pc32, tbl[i].pc32);
        chk("tbl_ir32", ir32, tbl[i].ir32);
      end
      chk("tbl_v16", 32'(v16), 32'(tbl[i].v16));
      chk("tbl_a16", a16, tbl[i].addr16);
      if (tbl[i].v16) begin
        chk("tbl_pc16", pc16, tbl[i].pc16);
        chk("tbl_ir16", ir16, tbl[i].ir16);
      end
    end

    // Backpressure: three stalled cycles plus the release cycle hold the slot.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, (i == 3) ? 1'b1 : 1'b0);
      chk("bp_v32", 32'(v32), 32'd1);
      chk("bp_pc32", pc32, 32'h10);
      chk("bp_ir32", ir32, mem32[4]);
      chk("bp_a32", a32, 32'h14);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("bp_next_pc32", pc32, 32'h14);
    chk("bp_next_ir32", ir32, mem32[5]);

    // Redirect to 0x20 while the 16-bit instance is in its second beat.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h20, 1'b1);
    chk("rb1_a16", a16, 32'h2);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rb1_v16_a", 32'(v16), 32'd0); chk("rb1_a16_a", a16, 32'h20);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rb1_v16_b", 32'(v16), 32'd0); chk("rb1_a16_b", a16, 32'h22);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rb1_v16_c", 32'(v16), 32'd1); chk("rb1_pc16", pc16, 32'h20);
    chk("rb1_ir16", ir16, {mem16[16], mem16[17]});

    // Misaligned redirect to 0x22.
    drive(1'b0, 1'b1, 32'h22, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mis_ae32", 32'(ae32), 32'd1); chk("mis_ae16", 32'(ae16), 32'd1);
    chk("mis_v32", 32'(v32), 32'd0);   chk("mis_a32", a32, 32'h20);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mis_ae32_off", 32'(ae32), 32'd0); chk("mis_ae16_off", 32'(ae16), 32'd0);
    chk("mis_pc32", pc32, 32'h20);         chk("mis_ir32", ir32, mem32[8]);

    // Reset together with a misaligned redirect, mid-stream.
    drive(1'b1, 1'b1, 32'h46, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rr_v32", 32'(v32), 32'd0);  chk("rr_v16", 32'(v16), 32'd0);
    chk("rr_a32", a32, 32'h0);       chk("rr_a16", a16, 32'h0);
    chk("rr_ae32", 32'(ae32), 32'd0); chk("rr_ae16", 32'(ae16), 32'd0);

    // pc wrap from 0xFFFF_FFFC to 0.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_a32", a32, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc32", pc32, 32'hFFFF_FFFC); chk("wrap_ir32", ir32, mem32[63]);
    chk("wrap_a32_0", a32, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc32_0", pc32, 32'h0);       chk("wrap_ir32_0", ir32, 32'h1111_1111);

    // Random traffic checked by the scoreboard.
    hs[0] = 0; hs[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 15) == 0),
            {($urandom_range(0, 1) == 1) ? 24'hFF_FFFF : 24'h00_0000, 8'($urandom_range(0, 255))},
            ($urandom_range(0, 3) != 0));
    end
    chk("rand_hs32_progress", 32'(hs[0] > 1000), 32'd1);
    chk("rand_hs16_progress", 32'(hs[1] > 400), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 The block SHALL have parameter MEM_WIDTH, default 32, which is the instruction-memory word width in bits; the only legal values are 16 and 32.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch byte address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: the byte address driven to instruction_memory.
REQ-006 The block SHALL have port imem_rdata, input, MEM_WIDTH bits: combinational read data for imem_addr, valid in the same cycle.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: a branch/jump redirect request.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits: the redirect target byte address.
REQ-009 The block SHALL have port if_valid, output, 1 bit: the output slot holds an instruction.
REQ-010 The block SHALL have port if_ready, input, 1 bit: decode accepts the slot.
REQ-011 The block SHALL have port if_pc, output, 32 bits: the byte address of if_ir.
REQ-012 The block SHALL have port if_ir, output, 32 bits: the assembled instruction word.
REQ-013 The block SHALL have port addr_error, output, 1 bit: a one-cycle pulse flagging a misaligned redirect.

Function
REQ-014 Constants: BEATS = 32/MEM_WIDTH (1 or 2); BEAT_BYTES = MEM_WIDTH/8.
REQ-015 State: fetch pc (32b), FSM {S_BEAT0, S_BEAT1}, staging register hi_half (16b, used only when BEATS=2), and the registered output slot.
REQ-016 imem_addr SHALL equal pc in S_BEAT0 and pc + 2 in S_BEAT1; it SHALL be combinational from registered state only.
REQ-017 Output slot is "free" when if_valid=0, or when if_valid=1 and if_ready=1.
REQ-018 BEATS=1: in S_BEAT0, if the slot is free, load if_ir<=imem_rdata and if_pc<=pc, set if_valid<=1, and set pc<=pc+4; otherwise hold all state.
REQ-019 BEATS=2, S_BEAT0: capture hi_half<=imem_rdata and go to S_BEAT1; this step is unconditional and independent of the slot.
REQ-020 BEATS=2, S_BEAT1: if the slot is free, load if_ir<={hi_half, imem_rdata} (big-endian, first beat is upper), load if_pc<=pc, set pc<=pc+4, and go to S_BEAT0; otherwise stay in S_BEAT1 re-reading the same address.
REQ-021 If the slot is free but no new instruction completes this cycle, if_valid SHALL go to 0.
REQ-022 if_valid, if_pc and if_ir SHALL be stable while if_valid=1 and if_ready=0.
REQ-023 Redirect has priority over all fetch activity: set pc<={redirect_pc[31:2],2'b00}, set FSM<=S_BEAT0, discard hi_half, and set if_valid<=0.
REQ-024 A handshake (if_valid and if_ready) in the redirect cycle SHALL still count as a completed transfer.
REQ-025 addr_error SHALL be registered and SHALL equal 1 for exactly the cycle after a redirect with redirect_pc[1:0] != 0; otherwise it SHALL be 0.
REQ-026 pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-027 Throughput with if_ready held at 1 SHALL be 1 instruction/cycle when BEATS=1 and 1 per 2 cycles when BEATS=2.
REQ-028 First-instruction latency SHALL be: if_valid=1 in the 1st cycle after reset deasserts (BEATS=1), or in the 2nd cycle (BEATS=2).

Reset
REQ-029 When reset=1 at a clock edge: pc<=RESET_PC, FSM<=S_BEAT0, hi_half<=0, if_valid<=0, if_pc<=0, if_ir<=0, addr_error<=0.
REQ-030 Reset SHALL override a simultaneous redirect_valid or handshake.
REQ-031 Reset asserted mid-fetch SHALL discard any partial instruction.
REQ-032 imem_addr SHALL equal RESET_PC in the cycle after reset.

Structure
REQ-033 Shared package fetch_pkg SHALL hold the FSM enum type fetch_state_t, INSTR_BYTES=4, and DEFAULT_RESET_PC.
REQ-034 One sub-module is natural: ir_assembler, which holds hi_half and the beat concatenation; it is a pass-through when BEATS=1.
REQ-035 instruction_memory SHALL NOT be instantiated inside this block; it is connected at the top level and in the bench.

Verification
REQ-036 MEM_WIDTH=32, memory words 0..3 = 11111111,22222222,33333333,44444444, if_ready=1: if_ir sequence SHALL be 11111111..44444444 on consecutive cycles, with if_pc 0,4,8,C.
REQ-037 MEM_WIDTH=16, halves ABCD,1234,5678,9ABC: if_ir SHALL be ABCD1234 (if_pc 0) then 56789ABC (if_pc 4), each 2 cycles apart.
REQ-038 Backpressure: hold if_ready=0 for 3 cycles with if_valid=1 -> if_ir/if_pc SHALL stay constant and imem_addr SHALL stay constant; on release, the next instruction SHALL follow the following cycle (BEATS=1).
REQ-039 Redirect to 32'h20 during S_BEAT1 (BEATS=2) -> no instruction from the old pc appears; the next if_pc SHALL be 32'h20.
REQ-040 Redirect to 32'h22 -> addr_error SHALL pulse one cycle and the fetch SHALL resume at 32'h20.
REQ-041 Assert reset for one cycle mid-stream alongside redirect_valid -> the cycle after, if_valid=0 and imem_addr=RESET_PC.
